// File: rtl/load_store_unit.sv
// Memory access stage: one byte/halfword/word load or store per start over a
// req/ack bus, with alignment checking, lane steering, load extension and timeout.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        memWrite,
    input  logic [2:0]  memOp,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    output logic        busy,
    output logic        done,
    output logic [31:0] loadData,
    output logic        addrError,
    output logic        busError,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memByteEn,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memAck
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    logic [15:0] count_reg;
    logic [2:0]  op_reg;
    logic [1:0]  offset_reg;

    logic        op_legal;
    logic        misaligned;
    logic [3:0]  lanes;
    logic [31:0] wdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Request decode from the live inputs; only used in IDLE when start is high.
    always_comb begin
        op_legal   = 1'b0;
        misaligned = 1'b0;
        lanes      = 4'b0000;
        wdata      = '0;
        case (memOp[1:0])
            2'b00: begin
                op_legal = !(memWrite && memOp[2]);
                lanes    = 4'b0001 << address[1:0];
                wdata    = {4{storeData[7:0]}};
            end
            2'b01: begin
                op_legal   = !(memWrite && memOp[2]);
                misaligned = address[0];
                lanes      = address[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{storeData[15:0]}};
            end
            2'b11: begin
                op_legal   = !memOp[2];
                misaligned = |address[1:0];
                lanes      = 4'b1111;
                wdata      = storeData;
            end
            default: ;
        endcase
        if (!memWrite) begin
            wdata = '0;
        end
    end

    // Extraction uses the latched op and byte offset, not the live inputs.
    always_comb begin
        byte_sel = memRdata[{offset_reg, 3'b000} +: 8];
        half_sel = offset_reg[1] ? memRdata[31:16] : memRdata[15:0];
        case (op_reg)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b011:  load_ext = memRdata;
            3'b100:  load_ext = {24'h000000, byte_sel};
            3'b101:  load_ext = {16'h0000, half_sel};
            default: load_ext = '0;
        endcase
    end

    assign busy   = ((state_reg == IDLE) && start) || (state_reg == ACCESS);
    assign memReq = (state_reg == ACCESS);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            op_reg     <= '0;
            offset_reg <= '0;
            done       <= 1'b0;
            addrError  <= 1'b0;
            busError   <= 1'b0;
            loadData   <= '0;
            memWe      <= 1'b0;
            memAddr    <= '0;
            memByteEn  <= '0;
            memWdata   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done      <= 1'b0;
                    addrError <= 1'b0;
                    busError  <= 1'b0;
                    if (start) begin
                        if (!op_legal || misaligned) begin
                            state_reg <= RESP;
                            done      <= 1'b1;
                            addrError <= 1'b1;
                            loadData  <= '0;
                        end else begin
                            state_reg  <= ACCESS;
                            count_reg  <= '0;
                            op_reg     <= memOp;
                            offset_reg <= address[1:0];
                            memWe      <= memWrite;
                            memAddr    <= {address[31:2], 2'b00};
                            memByteEn  <= lanes;
                            memWdata   <= wdata;
                        end
                    end
                end
                ACCESS: begin
                    // An ack in the final counted cycle still completes normally.
                    if (memAck) begin
                        state_reg <= RESP;
                        done      <= 1'b1;
                        loadData  <= memWe ? 32'h0 : load_ext;
                    end else if (count_reg == LAST_COUNT) begin
                        state_reg <= RESP;
                        done      <= 1'b1;
                        busError  <= 1'b1;
                        loadData  <= '0;
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    addrError <= 1'b0;
                    busError  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads/stores, lane steering, extension,
// alignment and reserved-op errors, timeout boundary and mid-access reset.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        memWrite;
    logic [2:0]  memOp;
    logic [31:0] address;
    logic [31:0] storeData;
    logic        busy;
    logic        done;
    logic [31:0] loadData;
    logic        addrError;
    logic        busError;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memByteEn;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memAck;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .memWrite  (memWrite),
        .memOp     (memOp),
        .address   (address),
        .storeData (storeData),
        .busy      (busy),
        .done      (done),
        .loadData  (loadData),
        .addrError (addrError),
        .busError  (busError),
        .memReq    (memReq),
        .memWe     (memWe),
        .memAddr   (memAddr),
        .memByteEn (memByteEn),
        .memWdata  (memWdata),
        .memRdata  (memRdata),
        .memAck    (memAck)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full successful access: start, (waits+1) ACCESS cycles with ack in the last, RESP.
    task automatic access(input string tag, input logic we, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input int waits, input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] ld);
        step();
        start = 1'b1; memWrite = we; memOp = op; address = a; storeData = sd;
        #1;
        chk({tag, " busy_start"}, 32'(busy), 32'd1);
        chk({tag, " req_start"}, 32'(memReq), 32'd0);
        for (int i = 0; i <= waits; i++) begin
            step();
            start = 1'b0;
            #1;
            chk($sformatf("%s req_c%0d", tag, i), 32'(memReq), 32'd1);
            chk($sformatf("%s busy_c%0d", tag, i), 32'(busy), 32'd1);
            chk($sformatf("%s done_c%0d", tag, i), 32'(done), 32'd0);
            chk($sformatf("%s addr_c%0d", tag, i), memAddr, {a[31:2], 2'b00});
            chk($sformatf("%s be_c%0d", tag, i), 32'(memByteEn), 32'(be));
            chk($sformatf("%s wdata_c%0d", tag, i), memWdata, wd);
            chk($sformatf("%s we_c%0d", tag, i), 32'(memWe), 32'(we));
            if (i == waits) begin
                memAck = 1'b1;
                memRdata = rd;
            end
        end
        step();
        memAck = 1'b0;
        memRdata = 32'hA5A5_5A5A;
        #1;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " loadData"}, loadData, ld);
        chk({tag, " addrError"}, 32'(addrError), 32'd0);
        chk({tag, " busError"}, 32'(busError), 32'd0);
        chk({tag, " busy_resp"}, 32'(busy), 32'd0);
        chk({tag, " req_resp"}, 32'(memReq), 32'd0);
        step();
        chk({tag, " done_after"}, 32'(done), 32'd0);
        $display("txn %s we=%0d op=%0d addr=%h loadData=%h", tag, we, op, a, loadData);
    endtask

    task automatic addr_err(input string tag, input logic we, input logic [2:0] op,
                            input logic [31:0] a);
        step();
        start = 1'b1; memWrite = we; memOp = op; address = a; storeData = 32'hFFFF_FFFF;
        #1;
        chk({tag, " busy_start"}, 32'(busy), 32'd1);
        step();
        start = 1'b1;   // start held high in RESP must be ignored
        #1;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " addrError"}, 32'(addrError), 32'd1);
        chk({tag, " busError"}, 32'(busError), 32'd0);
        chk({tag, " req"}, 32'(memReq), 32'd0);
        chk({tag, " busy_resp"}, 32'(busy), 32'd0);
        chk({tag, " loadData"}, loadData, 32'd0);
        start = 1'b0;
        step();
        chk({tag, " done_after"}, 32'(done), 32'd0);
        chk({tag, " addrError_after"}, 32'(addrError), 32'd0);
        chk({tag, " req_after"}, 32'(memReq), 32'd0);
        $display("txn %s op=%0d addr=%h addrError expected", tag, op, a);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; memWrite = 1'b0; memOp = 3'b000;
        address = '0; storeData = '0; memRdata = '0; memAck = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset req", 32'(memReq), 32'd0);
        chk("reset we", 32'(memWe), 32'd0);
        chk("reset addr", memAddr, 32'd0);
        chk("reset be", 32'(memByteEn), 32'd0);
        chk("reset wdata", memWdata, 32'd0);
        chk("reset loadData", loadData, 32'd0);
        chk("reset errs", {30'd0, addrError, busError}, 32'd0);

        // Stray ack while idle has no effect
        memAck = 1'b1;
        step();
        chk("idle ack done", 32'(done), 32'd0);
        chk("idle ack req", 32'(memReq), 32'd0);
        memAck = 1'b0;

        access("LB", 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 4'b1000, 32'h0, 32'hFFFF_FF80);
        access("SH", 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        access("SB", 1'b1, 3'b000, 32'h0000_3001, 32'h1122_33A5, 32'h0, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        access("LH", 1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 0, 4'b1100, 32'h0, 32'hFFFF_8001);
        access("LBU", 1'b0, 3'b100, 32'h0000_0006, 32'h0, 32'h00C3_0000, 0, 4'b0100, 32'h0, 32'h0000_00C3);
        access("LW", 1'b0, 3'b011, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, 2, 4'b1111, 32'h0, 32'hCAFE_F00D);
        // Ack in the 4th (last) ACCESS cycle: ack beats the timeout
        access("LHU", 1'b0, 3'b101, 32'h0000_0010, 32'h0, 32'h0000_8001, 3, 4'b0011, 32'h0, 32'h0000_8001);

        addr_err("LW_mis", 1'b0, 3'b011, 32'h0000_2001);
        addr_err("op110", 1'b0, 3'b110, 32'h0000_2000);
        addr_err("SH_mis", 1'b1, 3'b001, 32'h0000_2003);
        addr_err("SBU_res", 1'b1, 3'b100, 32'h0000_2000);

        // Timeout: four ACCESS cycles with no ack, then done with busError
        step();
        start = 1'b1; memWrite = 1'b0; memOp = 3'b011; address = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            step();
            start = 1'b0;
            chk($sformatf("TO req_c%0d", i), 32'(memReq), 32'd1);
            chk($sformatf("TO done_c%0d", i), 32'(done), 32'd0);
        end
        step();
        chk("TO done", 32'(done), 32'd1);
        chk("TO busError", 32'(busError), 32'd1);
        chk("TO addrError", 32'(addrError), 32'd0);
        chk("TO req", 32'(memReq), 32'd0);
        chk("TO loadData", loadData, 32'd0);
        step();
        chk("TO done_after", 32'(done), 32'd0);
        chk("TO busError_after", 32'(busError), 32'd0);
        $display("txn TIMEOUT addr=00000100 busError expected");

        // Produce a nonzero loadData, then reset during the 2nd ACCESS cycle
        access("LW2", 1'b0, 3'b011, 32'h0000_0200, 32'h0, 32'h1357_9BDF, 0, 4'b1111, 32'h0, 32'h1357_9BDF);
        step();
        start = 1'b1; memWrite = 1'b0; memOp = 3'b011; address = 32'h0000_0040;
        step();
        start = 1'b0;
        chk("RST req_c0", 32'(memReq), 32'd1);
        step();
        chk("RST req_c1", 32'(memReq), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("RST req", 32'(memReq), 32'd0);
        chk("RST busy", 32'(busy), 32'd0);
        chk("RST done", 32'(done), 32'd0);
        chk("RST loadData", loadData, 32'd0);
        chk("RST be", 32'(memByteEn), 32'd0);
        step();
        chk("RST idle req", 32'(memReq), 32'd0);
        $display("txn RESET mid-access");

        access("SW", 1'b1, 3'b011, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory access stage of the simple MIPS core, directly downstream of the execute ALU: takes the ALU result as effective address plus rt as store data, and performs one byte/halfword/word load or store against data memory over a request/acknowledge handshake. It handles alignment checking, byte-lane steering and load sign/zero extension, and stalls the core via `busy` until the access completes, faults, or times out.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum ACCESS cycles waiting for `memAck` before a bus error (legal range 2..65535).

- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: memory instruction present in execute; sampled only in IDLE.
- `memWrite` in 1: 1 = store, 0 = load.
- `memOp` in 3: access type.
  - Loads: 000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 011 SW.
  - All other codes are reserved.
- `address` in 32: effective address from the ALU result.
- `storeData` in 32: rt value.
- `busy` out 1: stall request to the core.
- `done` out 1: one-cycle completion pulse.
- `loadData` out 32: extended load result; held until the next accepted `start`.
- `addrError` out 1: misaligned address or reserved op; valid with `done`.
- `busError` out 1: timeout; valid with `done`.
- `memReq` out 1: request to data memory.
- `memWe` out 1: request is a write.
- `memAddr` out 32: word address, `{address[31:2], 2'b00}`.
- `memByteEn` out 4: byte lanes; bit i = bits [8i+7:8i].
- `memWdata` out 32: lane-replicated write data.
- `memRdata` in 32: read data, valid with `memAck`.
- `memAck` in 1: memory completion.

## Operation
- Byte order is little-endian: byte offset 0 maps to bits [7:0].
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - `start=1` with an aligned, legal op:
    - latch op, lanes, data and word address;
    - go to ACCESS;
    - clear the timeout counter.
  - `start=1` with a misaligned or reserved op: go to RESP with `addrError=1`; no memory request is issued.
  - Misaligned means halfword ops with `address[0]=1`, or word ops with `address[1:0]!=0`.
- **ACCESS**
  - `memReq=1`; all `mem*` outputs stay stable.
  - `memAck=1`: a load captures its extended data; go to RESP.
  - Otherwise the counter increments.
  - Counter reaching `TIMEOUT_CYCLES-1` with no ack: go to RESP with `busError=1`.
  - If `memAck` arrives in that same cycle, the ack wins and `busError` stays 0.
- **RESP**
  - `done=1` for one cycle, then return to IDLE unconditionally.
  - `start` is ignored in RESP.
- Byte lanes for both reads and writes:
  - byte ops: `memByteEn = 1 << address[1:0]`;
  - half ops: `address[1]` ? 1100 : 0011;
  - word ops: 1111.
- Write data:
  - SB: `{4{storeData[7:0]}}`;
  - SH: `{2{storeData[15:0]}}`;
  - SW: `storeData`;
  - loads: 0.
- Load extraction:
  - take the selected byte or halfword from `memRdata`;
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Stores and errors update `loadData` to 0.
- `memAck` outside ACCESS is ignored.
- `addrError` and `busError` are 0 whenever `done=0`.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - `busy`, `done`, `addrError`, `busError`, `memReq`, `memWe` all 0;
  - `memAddr`, `memByteEn`, `memWdata`, `loadData` all 0.
- `busy` is combinational: (IDLE & `start`) | ACCESS. It is 0 in RESP, so the core advances on the RESP edge.
- Latency from the `start` cycle:
  - ack in the first ACCESS cycle: `done` at cycle +2;
  - each wait cycle adds 1;
  - misaligned or reserved op: `done` at cycle +1;
  - timeout: `done` at cycle +1+`TIMEOUT_CYCLES`.
- `memReq` is high for exactly the ACCESS cycles. `memAck` is sampled on the rising edge.
- Reset asserted mid-ACCESS:
  - from the next cycle, all outputs take their reset values;
  - the abandoned memory request is dropped without completion;
  - the next `start` after reset is handled normally.

## Test plan
- LB at 0x00001003, `memRdata`=0x80FF1234, ack in the first ACCESS cycle:
  - `memAddr`=0x00001000, `memByteEn`=1000;
  - `done` at cycle +2 with `loadData`=0xFFFFFF80.
- SH at 0x00002002, `storeData`=0x1234ABCD, immediate ack:
  - `memWe`=1, `memByteEn`=1100, `memWdata`=0xABCDABCD;
  - `done` at +2 with `loadData`=0.
- LW at 0x00002001, and separately `memOp`=110:
  - `memReq` never asserted;
  - `done` at +1 with `addrError`=1 and `busy` high only in the `start` cycle.
- LHU at 0x00000010, ack delayed 3 cycles, `memRdata`=0x00008001:
  - `memReq`, `busy` and `mem*` are stable for 4 ACCESS cycles;
  - `loadData`=0x00008001, `done` at +5.
- `TIMEOUT_CYCLES`=4 with no ack:
  - `memReq` high for 4 cycles, then `done`+`busError`;
  - repeat with ack in the 4th cycle: expect normal completion and `busError`=0.
- `reset` asserted in the 2nd ACCESS cycle:
  - next cycle `memReq`/`busy`/`done`=0 and `loadData`=0;
  - a following SW at 0x00000000 (`storeData`=0xDEADBEEF) completes with `memByteEn`=1111 and `memWdata`=0xDEADBEEF.
